// File: rtl/imm_extend_stage.sv
// imm_extend_stage
//   Registered RISC-V immediate decode and sign-extension stage with a
//   valid/ready handshake on both sides.  A raw 32-bit instruction is
//   classified by opcode, its immediate is assembled and extended to XLEN
//   bits, and the result is presented one cycle after acceptance together
//   with a 3-bit format tag.
//
// Parameters
//   XLEN : datapath width, 32 or 64
//   SKID : 1 = two-entry buffer (output register + skid) with registered
//          in_ready; 0 = single output register, combinational in_ready
//
// Ports
//   clk         : rising-edge clock
//   reset       : synchronous, active-high reset
//   in_valid    : instr is valid
//   in_ready    : stage can accept instr this cycle
//   instr       : raw 32-bit instruction word
//   out_valid   : out_imm / out_fmt / out_illegal are valid
//   out_ready   : consumer accepts the output this cycle
//   out_imm     : extended immediate (XLEN bits)
//   out_fmt     : 0=R 1=I 2=S 3=B 4=U 5=J 6=Z(CSR zimm) 7=illegal
//   out_illegal : opcode not recognised (out_fmt == 7)
module imm_extend_stage #(
   parameter int XLEN = 32,
   parameter int SKID = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic            out_illegal
);

   localparam logic [2:0] FMT_R   = 3'd0;
   localparam logic [2:0] FMT_I   = 3'd1;
   localparam logic [2:0] FMT_S   = 3'd2;
   localparam logic [2:0] FMT_B   = 3'd3;
   localparam logic [2:0] FMT_U   = 3'd4;
   localparam logic [2:0] FMT_J   = 3'd5;
   localparam logic [2:0] FMT_Z   = 3'd6;
   localparam logic [2:0] FMT_ILL = 3'd7;

   // Every format's immediate fits in a signed 32-bit value whose bit 31
   // is instr[31] (or 0 for zimm/R/illegal), so the XLEN-wide result is a
   // plain sign extension of that value.
   function automatic logic [XLEN+2:0] decode(input logic [31:0] ins);
      logic signed [31:0] raw;
      logic        [2:0]  fmt;
      raw = '0;
      fmt = FMT_ILL;
      case (ins[6:0])
         7'b0000011, 7'b0010011, 7'b1100111: begin
            fmt = FMT_I;
            raw = {{20{ins[31]}}, ins[31:20]};
         end
         7'b0100011: begin
            fmt = FMT_S;
            raw = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         end
         7'b1100011: begin
            fmt = FMT_B;
            raw = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         end
         7'b0110111, 7'b0010111: begin
            fmt = FMT_U;
            raw = {ins[31:12], 12'b0};
         end
         7'b1101111: begin
            fmt = FMT_J;
            raw = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         end
         7'b1110011: begin
            // funct3[2] selects the immediate CSR forms (zimm in rs1 field)
            if (ins[14]) begin
               fmt = FMT_Z;
               raw = {27'b0, ins[19:15]};
            end else begin
               fmt = FMT_I;
               raw = {{20{ins[31]}}, ins[31:20]};
            end
         end
         7'b0110011: begin
            fmt = FMT_R;
            raw = '0;
         end
         default: begin
            fmt = FMT_ILL;
            raw = '0;
         end
      endcase
      return {fmt, XLEN'(raw)};
   endfunction

   // ---- stage p0: combinational decode of the incoming word ----
   logic signed [XLEN-1:0] imm_p0;
   logic        [2:0]      fmt_p0;

   always_comb begin
      {fmt_p0, imm_p0} = decode(instr);
   end

   logic accept;
   logic xfer;

   // ---- stage p1: output register (plus optional skid entry) ----
   logic                   vld_p1;
   logic signed [XLEN-1:0] imm_p1;
   logic        [2:0]      fmt_p1;

   assign accept = in_valid && in_ready;
   assign xfer   = vld_p1 && out_ready;

   generate
      if (SKID != 0) begin : g_skid
         logic                   skid_vld_p1;
         logic signed [XLEN-1:0] skid_imm_p1;
         logic        [2:0]      skid_fmt_p1;
         logic                   ready_r;

         always_ff @(posedge clk) begin
            if (reset) begin
               vld_p1      <= 1'b0;
               imm_p1      <= '0;
               fmt_p1      <= FMT_R;
               skid_vld_p1 <= 1'b0;
               skid_imm_p1 <= '0;
               skid_fmt_p1 <= FMT_R;
               ready_r     <= 1'b1;
            end else if (xfer && skid_vld_p1) begin
               // ready_r is low whenever the skid is full, so no accept here
               imm_p1      <= skid_imm_p1;
               fmt_p1      <= skid_fmt_p1;
               skid_vld_p1 <= 1'b0;
               ready_r     <= 1'b1;
            end else if (accept && (!vld_p1 || xfer)) begin
               vld_p1 <= 1'b1;
               imm_p1 <= imm_p0;
               fmt_p1 <= fmt_p0;
            end else if (accept) begin
               // output stalled: park the result behind it
               skid_vld_p1 <= 1'b1;
               skid_imm_p1 <= imm_p0;
               skid_fmt_p1 <= fmt_p0;
               ready_r     <= 1'b0;
            end else if (xfer) begin
               vld_p1 <= 1'b0;
            end
         end

         assign in_ready = ready_r;
      end else begin : g_noskid
         always_ff @(posedge clk) begin
            if (reset) begin
               vld_p1 <= 1'b0;
               imm_p1 <= '0;
               fmt_p1 <= FMT_R;
            end else if (accept) begin
               vld_p1 <= 1'b1;
               imm_p1 <= imm_p0;
               fmt_p1 <= fmt_p0;
            end else if (xfer) begin
               vld_p1 <= 1'b0;
            end
         end

         assign in_ready = !vld_p1 || out_ready;
      end
   endgenerate

   assign out_valid   = vld_p1;
   assign out_imm     = imm_p1;
   assign out_fmt     = fmt_p1;
   assign out_illegal = (fmt_p1 == FMT_ILL);

endmodule

// File: tb/tb_imm_extend_stage.sv
// tb_imm_extend_stage
//   Drives two instances (XLEN=32/SKID=1 and XLEN=64/SKID=0) from shared
//   stimulus and checks both against an in-bench reference: a decode
//   function written from the ISA immediate rules plus one queue per
//   instance holding results accepted but not yet transferred.
module tb_imm_extend_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] instr;

   logic        a_in_ready, a_out_valid, a_ill;
   logic [31:0] a_imm;
   logic [2:0]  a_fmt;
   logic        b_in_ready, b_out_valid, b_ill;
   logic [63:0] b_imm;
   logic [2:0]  b_fmt;

   imm_extend_stage #(.XLEN(32), .SKID(1)) u_a (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
      .instr(instr), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_imm(a_imm), .out_fmt(a_fmt), .out_illegal(a_ill));

   imm_extend_stage #(.XLEN(64), .SKID(0)) u_b (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
      .instr(instr), .out_valid(b_out_valid), .out_ready(out_ready),
      .out_imm(b_imm), .out_fmt(b_fmt), .out_illegal(b_ill));

   int vectors = 0;
   int miscompares = 0;

   // entries are {fmt, imm64}
   logic [66:0] qa[$];
   logic [66:0] qb[$];

   function automatic logic [66:0] ref_model(input logic [31:0] ins);
      longint      v;
      logic [2:0]  f;
      logic [11:0] s;
      logic [12:0] b;
      logic [20:0] j;
      v = 0;
      f = 3'd7;
      case (ins[6:0])
         7'h03, 7'h13, 7'h67: begin f = 3'd1; v = longint'($signed(ins[31:20])); end
         7'h23: begin
            f = 3'd2; s = {ins[31:25], ins[11:7]}; v = longint'($signed(s));
         end
         7'h63: begin
            f = 3'd3; b = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            v = longint'($signed(b));
         end
         7'h37, 7'h17: begin
            f = 3'd4; v = longint'($signed(ins & 32'hFFFF_F000));
         end
         7'h6F: begin
            f = 3'd5; j = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            v = longint'($signed(j));
         end
         7'h73: begin
            if (ins[14]) begin f = 3'd6; v = longint'(ins[19:15]); end
            else begin f = 3'd1; v = longint'($signed(ins[31:20])); end
         end
         7'h33: begin f = 3'd0; v = 0; end
         default: begin f = 3'd7; v = 0; end
      endcase
      return {f, v};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Cycle-level comparison against the model queues (called at negedge).
   task automatic compare_all();
      logic [66:0] e;
      chk("a_out_valid", 64'(a_out_valid), 64'(qa.size() > 0));
      chk("a_in_ready", 64'(a_in_ready), 64'(qa.size() < 2));
      if (qa.size() > 0) begin
         e = qa[0];
         chk("a_imm", 64'(a_imm), 64'(e[31:0]));
         chk("a_fmt", 64'(a_fmt), 64'(e[66:64]));
         chk("a_illegal", 64'(a_ill), 64'(e[66:64] == 3'd7));
      end
      chk("b_out_valid", 64'(b_out_valid), 64'(qb.size() > 0));
      if (qb.size() > 0) begin
         e = qb[0];
         chk("b_imm", b_imm, e[63:0]);
         chk("b_fmt", 64'(b_fmt), 64'(e[66:64]));
         chk("b_illegal", 64'(b_ill), 64'(e[66:64] == 3'd7));
      end
   endtask

   // One clock cycle: check, drive, advance model, wait for next negedge.
   task automatic step(input logic iv, input logic [31:0] ins, input logic ordy,
                       input logic rst, output logic acc_a);
      logic acc_b;
      compare_all();
      in_valid  = iv;
      instr     = ins;
      out_ready = ordy;
      reset     = rst;
      #1;
      acc_a = 1'b0;
      if (rst) begin
         qa.delete();
         qb.delete();
      end else begin
         chk("b_in_ready", 64'(b_in_ready), 64'(!b_out_valid || ordy));
         acc_a = iv && (qa.size() < 2);
         acc_b = iv && (qb.size() == 0 || ordy);
         if (qa.size() > 0 && ordy) void'(qa.pop_front());
         if (qb.size() > 0 && ordy) void'(qb.pop_front());
         if (acc_a) qa.push_back(ref_model(ins));
         if (acc_b) qb.push_back(ref_model(ins));
      end
      @(negedge clk);
   endtask

   logic [31:0] dv   [10];
   logic [63:0] de64 [10];
   logic [2:0]  dfmt [10];
   logic [6:0]  ops  [11];

   initial begin
      logic        acc;
      logic [31:0] r;
      logic [66:0] m;
      int          k;
      int          budget;

      dv[0] = 32'hFFF00093; de64[0] = 64'hFFFFFFFF_FFFFFFFF; dfmt[0] = 3'd1;
      dv[1] = 32'hFE000EE3; de64[1] = 64'hFFFFFFFF_FFFFFFFC; dfmt[1] = 3'd3;
      dv[2] = 32'h300FD073; de64[2] = 64'h00000000_0000001F; dfmt[2] = 3'd6;
      dv[3] = 32'h123450B7; de64[3] = 64'h00000000_12345000; dfmt[3] = 3'd4;
      dv[4] = 32'h800000B7; de64[4] = 64'hFFFFFFFF_80000000; dfmt[4] = 3'd4;
      dv[5] = 32'h00000000; de64[5] = 64'h0;                 dfmt[5] = 3'd7;
      dv[6] = 32'hFE112E23; de64[6] = 64'hFFFFFFFF_FFFFFFFC; dfmt[6] = 3'd2;
      dv[7] = 32'hFFDFF06F; de64[7] = 64'hFFFFFFFF_FFFFFFFC; dfmt[7] = 3'd5;
      dv[8] = 32'h002081B3; de64[8] = 64'h0;                 dfmt[8] = 3'd0;
      dv[9] = 32'h30009073; de64[9] = 64'h00000000_00000300; dfmt[9] = 3'd1;

      ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h0F};

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
      repeat (3) @(negedge clk);

      // reset state
      step(1'b0, 32'h0, 1'b1, 1'b0, acc);
      chk("rst_a_imm", 64'(a_imm), 64'h0);
      chk("rst_a_fmt", 64'(a_fmt), 64'h0);
      chk("rst_a_ill", 64'(a_ill), 64'h0);
      chk("rst_b_imm", b_imm, 64'h0);
      chk("rst_a_in_ready", 64'(a_in_ready), 64'h1);

      // directed vectors with literal expectations, one cycle after accept
      for (int i = 0; i < 10; i++) begin
         m = ref_model(dv[i]);
         chk("model_imm", m[63:0], de64[i]);
         chk("model_fmt", 64'(m[66:64]), 64'(dfmt[i]));
         step(1'b1, dv[i], 1'b1, 1'b0, acc);
         chk("lit_a_valid", 64'(a_out_valid), 64'h1);
         chk("lit_a_imm", 64'(a_imm), 64'(de64[i][31:0]));
         chk("lit_b_imm", b_imm, de64[i]);
         chk("lit_a_fmt", 64'(a_fmt), 64'(dfmt[i]));
         chk("lit_b_ill", 64'(b_ill), 64'(dfmt[i] == 3'd7));
      end
      step(1'b0, 32'h0, 1'b1, 1'b0, acc);

      // backpressure: out_ready low for cycles 0..3, four instructions
      k = 0;
      budget = 0;
      while ((k < 4 || qa.size() > 0) && budget < 40) begin
         step(k < 4, dv[k % 10], budget >= 4, 1'b0, acc);
         if (acc) k++;
         if (budget >= 1 && budget <= 3) begin
            chk("bp_in_ready_low", 64'(a_in_ready), 64'h0);
            chk("bp_stable_imm", 64'(a_imm), 64'(de64[0][31:0]));
            chk("bp_stable_valid", 64'(a_out_valid), 64'h1);
         end
         budget++;
      end
      chk("bp_all_accepted", 64'(k), 64'd4);
      chk("bp_drained", 64'(qa.size()), 64'd0);

      // reset with output and skid both full
      step(1'b1, dv[1], 1'b0, 1'b0, acc);
      step(1'b1, dv[2], 1'b0, 1'b0, acc);
      chk("pre_rst_valid", 64'(a_out_valid), 64'h1);
      chk("pre_rst_skid_full", 64'(a_in_ready), 64'h0);
      step(1'b0, 32'h0, 1'b0, 1'b1, acc);
      chk("post_rst_a_valid", 64'(a_out_valid), 64'h0);
      chk("post_rst_a_in_ready", 64'(a_in_ready), 64'h1);
      chk("post_rst_a_imm", 64'(a_imm), 64'h0);
      chk("post_rst_b_valid", 64'(b_out_valid), 64'h0);
      chk("post_rst_b_imm", b_imm, 64'h0);
      repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0, acc);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         r = $urandom;
         if ($urandom_range(0, 4) != 0) r[6:0] = ops[$urandom_range(0, 10)];
         step($urandom_range(0, 9) < 7, r, $urandom_range(0, 9) < 6,
              $urandom_range(0, 299) == 0, acc);
      end
      step(1'b0, 32'h0, 1'b1, 1'b0, acc);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
